// File: rtl/bsram_pkg.sv
// Shared definitions for the BSRAM controller: widths, default boot base,
// FSM state type and the read-tag record carried through the response pipe.
package bsram_pkg;

  localparam int AddrW = 13;
  localparam int DataW = 8;
  localparam logic [AddrW-1:0] BootBaseDefault = 13'h0200;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // One in-flight read: whether the slot is occupied and who asked for it.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/bsram_rd_arb.sv
// Two-requester round-robin read arbiter with a write-collision mask.
// A requester whose address matches a same-cycle write is held off so the
// read never races the write into the BSRAM; it simply retries next cycle.
module bsram_rd_arb
  import bsram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       rd_req,
  input  logic [AddrW-1:0] rd_addr0,
  input  logic [AddrW-1:0] rd_addr1,
  input  logic             wr_req,
  input  logic [AddrW-1:0] wr_addr,
  output logic [1:0]       grant
);

  // Requester that wins a tie; 0 out of reset.
  logic       prio;
  logic [1:0] eligible;

  // Mask colliding requesters, then resolve a tie with the priority pointer.
  always_comb begin
    eligible    = 2'b00;
    eligible[0] = en & rd_req[0] & ~(wr_req & (wr_addr == rd_addr0));
    eligible[1] = en & rd_req[1] & ~(wr_req & (wr_addr == rd_addr1));
    grant       = eligible;
    if (eligible == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

  // After a grant, hand priority to the other requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant[0]) begin
      prio <= 1'b1;
    end else if (grant[1]) begin
      prio <= 1'b0;
    end
  end

endmodule

// File: rtl/bsram_ctrl.sv
// BSRAM controller: loads the memory from a boot byte stream, then serves
// CPU writes and arbitrated CPU/LCD reads. The BSRAM has a registered
// address stage and a pipelined output register, so read data appears two
// edges after the address is presented; a tag pipe tracks it alongside.
module bsram_ctrl
  import bsram_pkg::*;
#(
  parameter logic [AddrW-1:0] BOOT_BASE = BootBaseDefault
) (
  input  logic             clk,
  input  logic             rst,
  // boot stream
  input  logic             boot_valid,
  input  logic [DataW-1:0] boot_data,
  input  logic             boot_last,
  output logic             boot_ready,
  output logic             boot_done,
  // CPU write
  input  logic             wr_req,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [DataW-1:0] wr_data,
  output logic             wr_ready,
  // reads (0 = CPU, 1 = LCD)
  input  logic [1:0]       rd_req,
  input  logic [AddrW-1:0] rd_addr0,
  input  logic [AddrW-1:0] rd_addr1,
  output logic [1:0]       rd_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [DataW-1:0] rsp_data,
  // BSRAM write port
  output logic             mem_cea,
  output logic [AddrW-1:0] mem_ada,
  output logic [DataW-1:0] mem_din,
  // BSRAM read port
  output logic             mem_ceb,
  output logic             mem_oce,
  output logic [AddrW-1:0] mem_adb,
  input  logic [DataW-1:0] mem_dout
);

  state_e           state;
  logic [AddrW-1:0] idx;
  logic [1:0]       grant;
  logic             boot_fire;
  logic             wr_fire;
  rd_tag_t          tag_a;
  rd_tag_t          tag_b;

  assign wr_ready  = (state == S_RUN);
  assign mem_oce   = (state == S_RUN);
  assign rd_ready  = grant;
  assign boot_fire = (state == S_BOOT) & boot_valid & boot_ready;
  assign wr_fire   = (state == S_RUN) & wr_req;
  // Data comes straight from the BSRAM output register; zeroed when idle.
  assign rsp_data  = rsp_valid ? mem_dout : '0;

  bsram_rd_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (state == S_RUN),
    .rd_req   (rd_req),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .grant    (grant)
  );

  // Boot/run FSM: counts boot beats, leaves boot on the last beat for good.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BOOT;
      boot_ready <= 1'b0;
      boot_done  <= 1'b0;
      idx        <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          boot_ready <= 1'b1;
          if (boot_fire) begin
            idx <= idx + 1'b1;
            if (boot_last) begin
              state      <= S_RUN;
              boot_ready <= 1'b0;
              boot_done  <= 1'b1;
            end
          end
        end
        default: begin
          boot_ready <= 1'b0;
          boot_done  <= 1'b1;
        end
      endcase
    end
  end

  // Write-port mux: boot beats in S_BOOT, CPU writes in S_RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cea <= 1'b0;
      mem_ada <= '0;
      mem_din <= '0;
    end else begin
      mem_cea <= 1'b0;
      if (boot_fire) begin
        mem_cea <= 1'b1;
        mem_ada <= BOOT_BASE + idx;
        mem_din <= boot_data;
      end else if (wr_fire) begin
        mem_cea <= 1'b1;
        mem_ada <= wr_addr;
        mem_din <= wr_data;
      end
    end
  end

  // Read issue: present the granted address to the BSRAM and open a tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ceb <= 1'b0;
      mem_adb <= '0;
      tag_a   <= '0;
    end else begin
      mem_ceb     <= |grant;
      tag_a.valid <= |grant;
      tag_a.id    <= grant[1];
      if (|grant) begin
        mem_adb <= grant[1] ? rd_addr1 : rd_addr0;
      end
    end
  end

  // Tag pipe: follows the BSRAM address and output-register stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      tag_b     <= tag_a;
      rsp_valid <= tag_b.valid;
      rsp_id    <= tag_b.id;
    end
  end

endmodule

// File: tb/tb_bsram_ctrl.sv
// Randomized self-checking bench for bsram_ctrl. A behavioural BSRAM model
// serves the read port; a reference model of the controller rules (who may
// be granted, what lands in memory, when responses arrive) predicts outputs.
module tb_bsram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot_valid = 1'b0;
  logic [7:0]  boot_data = '0;
  logic        boot_last = 1'b0;
  logic        wr_req = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [1:0]  rd_req = '0;
  logic [12:0] rd_addr0 = '0;
  logic [12:0] rd_addr1 = '0;

  logic        boot_ready, boot_done, wr_ready, rsp_valid, rsp_id;
  logic [1:0]  rd_ready;
  logic [7:0]  rsp_data, mem_din;
  logic        mem_cea, mem_ceb, mem_oce;
  logic [12:0] mem_ada, mem_adb;
  logic [7:0]  mem_dout = '0;

  logic        w_boot_ready, w_boot_done, w_wr_ready, w_rsp_valid, w_rsp_id;
  logic [1:0]  w_rd_ready;
  logic [7:0]  w_rsp_data, w_mem_din;
  logic        w_mem_cea, w_mem_ceb, w_mem_oce;
  logic [12:0] w_mem_ada, w_mem_adb;
  logic [7:0]  w_mem_dout = '0;

  always #5 clk = ~clk;

  bsram_ctrl u_dut (
    .clk(clk), .rst(rst),
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
    .boot_ready(boot_ready), .boot_done(boot_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mem_cea(mem_cea), .mem_ada(mem_ada), .mem_din(mem_din),
    .mem_ceb(mem_ceb), .mem_oce(mem_oce), .mem_adb(mem_adb), .mem_dout(mem_dout)
  );

  // Second instance only exercises the boot address wrap at the top of memory.
  bsram_ctrl #(.BOOT_BASE(13'h1FFE)) u_wrap (
    .clk(clk), .rst(rst),
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
    .boot_ready(w_boot_ready), .boot_done(w_boot_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(w_wr_ready),
    .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_ready(w_rd_ready),
    .rsp_valid(w_rsp_valid), .rsp_id(w_rsp_id), .rsp_data(w_rsp_data),
    .mem_cea(w_mem_cea), .mem_ada(w_mem_ada), .mem_din(w_mem_din),
    .mem_ceb(w_mem_ceb), .mem_oce(w_mem_oce), .mem_adb(w_mem_adb), .mem_dout(w_mem_dout)
  );

  // BSRAM model: registered address/read stage, then pipelined output register.
  logic [7:0] bram [8192];
  logic [7:0] bram_q = '0;
  always @(posedge clk) begin
    if (mem_cea) bram[mem_ada] <= mem_din;
    if (mem_ceb) bram_q <= bram[mem_adb];
    if (mem_oce) mem_dout <= bram_q;
  end

  // Reference model state.
  typedef struct {
    int         due;
    logic       id;
    logic [7:0] data;
  } rsp_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          m_run = 0;
  bit          m_boot_rdy = 0;
  int          m_last = -1;
  logic [12:0] m_idx = '0;
  logic [7:0]  ref_mem [8192];
  rsp_t        exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Apply the inputs already driven for one clock and check both sides of the edge.
  task automatic step();
    bit          exp_brdy, e0, e1, boot_acc, wr_acc;
    int          g;
    logic [12:0] ga;
    logic [12:0] exp_ada;
    rsp_t        r;
    #1;
    exp_brdy = m_boot_rdy && !m_run;
    check("boot_ready", boot_ready, exp_brdy);
    check("wr_ready", wr_ready, m_run);
    check("mem_oce", mem_oce, m_run);
    e0 = m_run && rd_req[0] && !(wr_req && wr_addr == rd_addr0);
    e1 = m_run && rd_req[1] && !(wr_req && wr_addr == rd_addr1);
    g = -1;
    if (e0 && e1) g = (m_last == 0) ? 1 : 0;
    else if (e0) g = 0;
    else if (e1) g = 1;
    check("rd_ready", rd_ready, (g < 0) ? 0 : (1 << g));
    boot_acc = boot_valid && exp_brdy;
    wr_acc = m_run && wr_req;

    @(posedge clk);
    cyc++;
    #1;
    if (boot_acc) begin
      exp_ada = 13'h0200 + m_idx;
      check("boot_cea", mem_cea, 1);
      check("boot_ada", mem_ada, exp_ada);
      check("boot_din", mem_din, boot_data);
      check("wrap_cea", w_mem_cea, 1);
      check("wrap_ada", w_mem_ada, 13'(13'h1FFE + m_idx));
      ref_mem[exp_ada] = boot_data;
      m_idx = m_idx + 13'd1;
      if (boot_last) m_run = 1;
      $display("boot beat %0h -> addr %0h", boot_data, exp_ada);
    end else if (wr_acc) begin
      check("wr_cea", mem_cea, 1);
      check("wr_ada", mem_ada, wr_addr);
      check("wr_din", mem_din, wr_data);
      ref_mem[wr_addr] = wr_data;
    end else begin
      check("mem_cea", mem_cea, 0);
    end
    if (g >= 0) begin
      ga = (g == 1) ? rd_addr1 : rd_addr0;
      check("mem_ceb", mem_ceb, 1);
      check("mem_adb", mem_adb, ga);
      r.due = cyc + 2;
      r.id = (g == 1);
      r.data = ref_mem[ga];
      exp_q.push_back(r);
      m_last = g;
    end else begin
      check("mem_ceb", mem_ceb, 0);
    end
    m_boot_rdy = 1;
    check("boot_done", boot_done, m_run);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, r.id);
      check("rsp_data", rsp_data, r.data);
      $display("read rsp id=%0d data=%0h", rsp_id, rsp_data);
    end else begin
      check("rsp_valid", rsp_valid, 0);
    end
    @(negedge clk);
  endtask

  // Assert reset at a negedge, check the cleared outputs, release two edges later.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_boot_ready", boot_ready, 0);
    check("rst_boot_done", boot_done, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mem_cea", mem_cea, 0);
    check("rst_mem_ceb", mem_ceb, 0);
    check("rst_mem_oce", mem_oce, 0);
    check("rst_mem_ada", mem_ada, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_mem_adb", mem_adb, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_rsp_valid", rsp_valid, 0);
      check("rst_hold_boot_ready", boot_ready, 0);
    end
    m_run = 0;
    m_boot_rdy = 0;
    m_last = -1;
    m_idx = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    boot_valid = 0; boot_last = 0; wr_req = 0; rd_req = 2'b00;
  endtask

  initial begin
    logic [7:0] boot_bytes [4];
    boot_bytes[0] = 8'h06; boot_bytes[1] = 8'h07;
    boot_bytes[2] = 8'h08; boot_bytes[3] = 8'h09;
    for (int i = 0; i < 8192; i++) begin
      bram[i] = '0;
      ref_mem[i] = '0;
    end

    @(negedge clk);
    do_reset();

    // Boot with reads and writes pushing against the gate the whole time.
    rd_req = 2'b11; rd_addr0 = 13'h0200; rd_addr1 = 13'h0201;
    wr_req = 1; wr_addr = 13'h0200; wr_data = 8'hEE;
    step();
    for (int b = 0; b < 4; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        boot_valid = 0;
        step();
      end
      boot_valid = 1; boot_data = boot_bytes[b]; boot_last = (b == 3);
      step();
    end
    idle_inputs();
    step();

    // Read back the boot image through requester 0.
    for (int a = 0; a < 4; a++) begin
      rd_req = 2'b01; rd_addr0 = 13'h0200 + 13'(a);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Contention: both requesters for four cycles.
    rd_req = 2'b10; rd_addr1 = 13'h0203;
    step();
    rd_req = 2'b11; rd_addr0 = 13'h0200; rd_addr1 = 13'h0201;
    repeat (4) step();
    idle_inputs();
    repeat (3) step();

    // Collision: read of 0x0300 held off by a same-cycle write, then granted.
    rd_req = 2'b01; rd_addr0 = 13'h0300;
    wr_req = 1; wr_addr = 13'h0300; wr_data = 8'h5A;
    step();
    wr_req = 0;
    step();
    idle_inputs();
    repeat (3) step();

    // Random traffic over a small address window so collisions are common.
    for (int n = 0; n < 400; n++) begin
      rd_req = 2'($urandom_range(0, 3));
      rd_addr0 = 13'h0300 + 13'($urandom_range(0, 7));
      rd_addr1 = 13'h0300 + 13'($urandom_range(0, 7));
      wr_req = ($urandom_range(0, 1) == 1);
      wr_addr = 13'h0300 + 13'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      boot_valid = ($urandom_range(0, 3) == 0);
      boot_data = 8'($urandom);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Reset one cycle after a grant: the read must never respond.
    rd_req = 2'b01; rd_addr0 = 13'h0301;
    step();
    rd_req = 2'b00;
    step();
    do_reset();
    repeat (4) step();
    check("post_rst_boot_ready", boot_ready, 1);
    check("post_rst_boot_done", boot_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
